// File: rtl/xm_debug_port.sv
// Debugger-facing responder: halts the core at instruction boundaries, runs single steps,
// and services debug register-file and memory accesses on the shared memory bus.
module xm_debug_port #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
) (
  input  logic          clk_i,
  input  logic          arst_i,
  input  logic          debug_i,
  input  logic          regWr_i,
  input  logic [2:0]    regAddr_i,
  input  logic [DW-1:0] regData_i,
  input  logic          memEn_i,
  input  logic          memWe_i,
  input  logic [AW-1:0] memAddr_i,
  input  logic [DW-1:0] memData_i,
  output logic          cpuEn_o,
  output logic [AW-1:0] pc_o,
  output logic [DW-1:0] reg_o,
  output logic [DW-1:0] mem_o,
  output logic [15:0]   step_count_o,
  output logic          core_halt_o,
  input  logic          core_done_i,
  input  logic [AW-1:0] core_pc_i,
  input  logic          core_mem_en_i,
  input  logic          core_mem_we_i,
  input  logic [AW-1:0] core_mem_addr_i,
  input  logic [DW-1:0] core_mem_wdata_i,
  output logic          rf_we_o,
  output logic [2:0]    rf_addr_o,
  output logic [DW-1:0] rf_wdata_o,
  input  logic [DW-1:0] rf_rdata_i,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ready_i
);

  typedef enum logic [1:0] {StHalted, StStep, StMemRd, StMemWr} state_e;

  state_e        state_q;
  logic          cpu_en_q;
  logic          core_halt_q;
  logic          wr_pend_q;
  logic          step_pend_q;
  logic [DW-1:0] mem_q;
  logic [15:0]   step_count_q;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_data_q;
  logic          wr_strobe;

  assign wr_strobe = memEn_i & memWe_i;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q      <= StHalted;
      cpu_en_q     <= 1'b0;
      core_halt_q  <= 1'b1;
      wr_pend_q    <= 1'b0;
      step_pend_q  <= 1'b0;
      mem_q        <= '0;
      step_count_q <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      unique case (state_q)
        StHalted: begin
          if (step_pend_q || !debug_i) begin
            state_q     <= StStep;
            cpu_en_q    <= 1'b1;
            core_halt_q <= 1'b0;
            step_pend_q <= 1'b0;
            // A write strobe coinciding with the step must not be dropped.
            if (wr_strobe) begin
              wr_pend_q <= 1'b1;
              wr_addr_q <= memAddr_i;
              wr_data_q <= memData_i;
            end
          end else if (wr_pend_q || wr_strobe) begin
            state_q   <= StMemWr;
            wr_pend_q <= 1'b1;
            if (wr_strobe) begin
              wr_addr_q <= memAddr_i;
              wr_data_q <= memData_i;
            end
          end else if (memEn_i) begin
            state_q <= StMemRd;
          end
        end
        StStep: begin
          if (wr_strobe) begin
            wr_pend_q <= 1'b1;
            wr_addr_q <= memAddr_i;
            wr_data_q <= memData_i;
          end
          if (core_done_i) begin
            state_q      <= StHalted;
            cpu_en_q     <= 1'b0;
            core_halt_q  <= 1'b1;
            step_count_q <= step_count_q + 16'd1;
          end
        end
        StMemRd: begin
          if (wr_strobe) begin
            wr_pend_q <= 1'b1;
            wr_addr_q <= memAddr_i;
            wr_data_q <= memData_i;
          end
          if (!debug_i) step_pend_q <= 1'b1;
          if (mem_ready_i) begin
            mem_q   <= mem_rdata_i;
            state_q <= StHalted;
          end
        end
        StMemWr: begin
          if (!debug_i) step_pend_q <= 1'b1;
          if (mem_ready_i) begin
            wr_pend_q <= 1'b0;
            state_q   <= StHalted;
          end
        end
        default: state_q <= StHalted;
      endcase
    end
  end

  // Bus ownership follows the state; the read address tracks memAddr_i live.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (state_q)
      StStep: begin
        mem_en_o    = core_mem_en_i;
        mem_we_o    = core_mem_we_i;
        mem_addr_o  = core_mem_addr_i;
        mem_wdata_o = core_mem_wdata_i;
      end
      StMemRd: begin
        mem_en_o   = 1'b1;
        mem_addr_o = memAddr_i;
      end
      StMemWr: begin
        mem_en_o    = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = wr_addr_q;
        mem_wdata_o = wr_data_q;
      end
      default: ;
    endcase
  end

  assign rf_we_o      = regWr_i & (state_q != StStep);
  assign rf_addr_o    = regAddr_i;
  assign rf_wdata_o   = regData_i;
  assign reg_o        = rf_rdata_i;
  assign pc_o         = core_pc_i;
  assign cpuEn_o      = cpu_en_q;
  assign core_halt_o  = core_halt_q;
  assign mem_o        = mem_q;
  assign step_count_o = step_count_q;

endmodule

// File: tb/tb_xm_debug_port.sv
// Randomized bench for xm_debug_port against a transaction-level memory/step model.
module tb_xm_debug_port;

  logic        clk_i = 1'b0;
  logic        arst_i = 1'b1;
  logic        debug_i = 1'b1;
  logic        regWr_i = 1'b0;
  logic [2:0]  regAddr_i = '0;
  logic [15:0] regData_i = '0;
  logic        memEn_i = 1'b0;
  logic        memWe_i = 1'b0;
  logic [15:0] memAddr_i = '0;
  logic [15:0] memData_i = '0;
  logic        cpuEn_o;
  logic [15:0] pc_o;
  logic [15:0] reg_o;
  logic [15:0] mem_o;
  logic [15:0] step_count_o;
  logic        core_halt_o;
  logic        core_done_i = 1'b0;
  logic [15:0] core_pc_i = '0;
  logic        core_mem_en_i = 1'b0;
  logic        core_mem_we_i = 1'b0;
  logic [15:0] core_mem_addr_i = '0;
  logic [15:0] core_mem_wdata_i = '0;
  logic        rf_we_o;
  logic [2:0]  rf_addr_o;
  logic [15:0] rf_wdata_o;
  logic [15:0] rf_rdata_i = '0;
  logic        mem_en_o;
  logic        mem_we_o;
  logic [15:0] mem_addr_o;
  logic [15:0] mem_wdata_o;
  logic [15:0] mem_rdata_i = '0;
  logic        mem_ready_i = 1'b0;

  xm_debug_port #(.AW(16), .DW(16)) dut (
    .clk_i(clk_i), .arst_i(arst_i), .debug_i(debug_i), .regWr_i(regWr_i),
    .regAddr_i(regAddr_i), .regData_i(regData_i), .memEn_i(memEn_i), .memWe_i(memWe_i),
    .memAddr_i(memAddr_i), .memData_i(memData_i), .cpuEn_o(cpuEn_o), .pc_o(pc_o),
    .reg_o(reg_o), .mem_o(mem_o), .step_count_o(step_count_o), .core_halt_o(core_halt_o),
    .core_done_i(core_done_i), .core_pc_i(core_pc_i), .core_mem_en_i(core_mem_en_i),
    .core_mem_we_i(core_mem_we_i), .core_mem_addr_i(core_mem_addr_i),
    .core_mem_wdata_i(core_mem_wdata_i), .rf_we_o(rf_we_o), .rf_addr_o(rf_addr_o),
    .rf_wdata_o(rf_wdata_o), .rf_rdata_i(rf_rdata_i), .mem_en_o(mem_en_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {logic we; logic [15:0] addr; logic [15:0] data;} bus_t;

  bus_t        log_q[$];
  logic [15:0] ram     [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic [15:0] ref_steps = '0;
  int unsigned mem_wait = 0;
  int unsigned wait_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Memory device: acks after mem_wait idle cycles, logs each completed transaction.
  always @(negedge clk_i) begin
    #2;
    if (arst_i || !mem_en_o) begin
      mem_ready_i = 1'b0;
      wait_cnt    = 0;
      mem_rdata_i = 16'($urandom);
    end else if (wait_cnt == mem_wait) begin
      mem_ready_i = 1'b1;
      wait_cnt    = 0;
      if (mem_we_o) begin
        ram[mem_addr_o] = mem_wdata_o;
        mem_rdata_i = 16'($urandom);
        log_q.push_back('{we: 1'b1, addr: mem_addr_o, data: mem_wdata_o});
      end else begin
        mem_rdata_i = ram[mem_addr_o];
        log_q.push_back('{we: 1'b0, addr: mem_addr_o, data: ram[mem_addr_o]});
      end
    end else begin
      mem_ready_i = 1'b0;
      wait_cnt++;
      mem_rdata_i = 16'($urandom);
    end
  end

  task automatic wait_idle();
    int cyc = 0;
    while (mem_en_o && cyc < 64) begin
      @(negedge clk_i); #3; cyc++;
    end
    check_eq("idle_timeout", 32'(mem_en_o), 32'd0);
  endtask

  task automatic do_read(input logic [15:0] addr, input int unsigned w, input bit keep_en);
    int unsigned n0;
    int unsigned cyc;
    mem_wait = w;
    n0 = log_q.size();
    @(negedge clk_i);
    memEn_i = 1'b1; memWe_i = 1'b0; memAddr_i = addr;
    cyc = 0;
    while (log_q.size() == n0 && cyc < 64) begin
      @(negedge clk_i); #3; cyc++;
    end
    check_eq("rd_latency", cyc, w + 1);
    if (log_q.size() > n0) check_eq("rd_addr", 32'(log_q[n0].addr), 32'(addr));
    @(negedge clk_i);
    if (!keep_en) memEn_i = 1'b0;
    #1;
    check_eq("rd_data", 32'(mem_o), 32'(ref_mem[addr]));
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [15:0] data, input int unsigned w);
    int unsigned n0;
    int unsigned cyc;
    mem_wait = w;
    n0 = log_q.size();
    @(negedge clk_i);
    memEn_i = 1'b1; memWe_i = 1'b1; memAddr_i = addr; memData_i = data;
    cyc = 0;
    do begin
      @(negedge clk_i);
      if (cyc == 0) begin
        memEn_i = 1'b0; memWe_i = 1'b0; memAddr_i = 16'($urandom); memData_i = 16'($urandom);
      end
      #3; cyc++;
      check_eq("wr_bus_we", 32'(mem_en_o & mem_we_o), 32'd1);
      check_eq("wr_bus_addr", 32'(mem_addr_o), 32'(addr));
      check_eq("wr_bus_data", 32'(mem_wdata_o), 32'(data));
    end while (log_q.size() == n0 && cyc < 64);
    check_eq("wr_latency", cyc, w + 1);
    ref_mem[addr] = data;
    @(negedge clk_i); #1;
    check_eq("wr_bus_released", 32'(mem_en_o), 32'd0);
  endtask

  task automatic do_step(input int unsigned dly);
    int unsigned hi = 0;
    @(negedge clk_i);
    debug_i = 1'b0;
    for (int c = 1; c <= int'(dly) + 1; c++) begin
      @(negedge clk_i);
      debug_i          = 1'b1;
      core_mem_en_i    = 1'($urandom_range(0, 1));
      core_mem_we_i    = ~core_mem_en_i;
      core_mem_addr_i  = 16'($urandom);
      core_mem_wdata_i = 16'($urandom);
      regWr_i          = (c == 1);
      core_done_i      = (c == int'(dly) + 1);
      #1;
      if (cpuEn_o) hi++;
      check_eq("step_halt_low", 32'(core_halt_o), 32'd0);
      check_eq("step_bus_en", 32'(mem_en_o), 32'(core_mem_en_i));
      check_eq("step_bus_we", 32'(mem_we_o), 32'(core_mem_we_i));
      check_eq("step_bus_addr", 32'(mem_addr_o), 32'(core_mem_addr_i));
      if (c == 1) check_eq("step_rf_we_blocked", 32'(rf_we_o), 32'd0);
    end
    @(negedge clk_i);
    core_done_i = 1'b0; core_mem_en_i = 1'b0; core_mem_we_i = 1'b0; regWr_i = 1'b0;
    #1;
    ref_steps = ref_steps + 16'd1;
    check_eq("step_cpuen_cycles", hi, dly + 1);
    check_eq("step_cpuen_off", 32'(cpuEn_o), 32'd0);
    check_eq("step_halt_back", 32'(core_halt_o), 32'd1);
    check_eq("step_count", 32'(step_count_o), 32'(ref_steps));
  endtask

  task automatic do_reg(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk_i);
    regWr_i = 1'b1; regAddr_i = a; regData_i = d;
    rf_rdata_i = 16'($urandom); core_pc_i = 16'($urandom);
    #1;
    check_eq("rf_we", 32'(rf_we_o), 32'd1);
    check_eq("rf_addr", 32'(rf_addr_o), 32'(a));
    check_eq("rf_wdata", 32'(rf_wdata_o), 32'(d));
    check_eq("reg_out", 32'(reg_o), 32'(rf_rdata_i));
    check_eq("pc_out", 32'(pc_o), 32'(core_pc_i));
    @(negedge clk_i);
    regWr_i = 1'b0;
    #1;
    check_eq("rf_we_off", 32'(rf_we_o), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n0;
    int unsigned cyc;
    int unsigned extra;
    logic [15:0] addr;
    for (int i = 0; i < 65536; i++) begin
      ram[i]     = 16'(i * 7 + 3);
      ref_mem[i] = 16'(i * 7 + 3);
    end
    ram[16'h0040]     = 16'hBEEF;
    ref_mem[16'h0040] = 16'hBEEF;

    repeat (2) @(negedge clk_i);
    check_eq("rst_cpuen", 32'(cpuEn_o), 32'd0);
    check_eq("rst_halt", 32'(core_halt_o), 32'd1);
    check_eq("rst_mem_o", 32'(mem_o), 32'd0);
    check_eq("rst_steps", 32'(step_count_o), 32'd0);
    check_eq("rst_bus_idle", 32'(mem_en_o), 32'd0);
    arst_i = 1'b0;

    do_reg(3'd5, 16'hA5A5);

    // Polling read of 0x0040 with two wait states.
    do_read(16'h0040, 2, 1'b1);
    n0 = log_q.size();
    repeat (12) @(negedge clk_i);
    extra = log_q.size() - n0;
    memEn_i = 1'b0;
    #3;
    wait_idle();
    check_eq("poll_repeat", 32'(extra >= 2), 32'd1);
    check_eq("poll_data", 32'(mem_o), 32'hBEEF);

    do_step(5);
    do_write(16'h0100, 16'h1234, 3);
    do_read(16'h0100, 1, 1'b0);

    // Write strobe while a read is waiting on ready.
    mem_wait = 4;
    n0 = log_q.size();
    @(negedge clk_i); memEn_i = 1'b1; memAddr_i = 16'h0300;
    @(negedge clk_i);
    @(negedge clk_i); memWe_i = 1'b1; memAddr_i = 16'h0310; memData_i = 16'hC0DE;
    @(negedge clk_i); memWe_i = 1'b0; memAddr_i = 16'h0300;
    cyc = 0;
    while (log_q.size() < n0 + 2 && cyc < 64) begin
      @(negedge clk_i); #3; cyc++;
    end
    @(negedge clk_i); memEn_i = 1'b0; #1;
    check_eq("wdr_count", log_q.size() - n0, 32'd2);
    if (log_q.size() >= n0 + 2) begin
      check_eq("wdr_first_rd", 32'({log_q[n0].we, log_q[n0].addr}), 32'({1'b0, 16'h0300}));
      check_eq("wdr_second_wr", 32'({log_q[n0+1].we, log_q[n0+1].addr}), 32'({1'b1, 16'h0310}));
      check_eq("wdr_second_data", 32'(log_q[n0+1].data), 32'hC0DE);
    end
    check_eq("wdr_rd_data", 32'(mem_o), 32'(ref_mem[16'h0300]));
    ref_mem[16'h0310] = 16'hC0DE;
    wait_idle();
    do_read(16'h0310, 0, 1'b0);

    // Step request arriving during a read is served once the read ends.
    mem_wait = 3;
    n0 = log_q.size();
    @(negedge clk_i); memEn_i = 1'b1; memAddr_i = 16'h0050;
    @(negedge clk_i); debug_i = 1'b0;
    @(negedge clk_i); debug_i = 1'b1;
    cyc = 0;
    while (log_q.size() == n0 && cyc < 64) begin
      @(negedge clk_i); #3; cyc++;
    end
    @(negedge clk_i); memEn_i = 1'b0; #1;
    check_eq("spend_wait", 32'(cpuEn_o), 32'd0);
    check_eq("spend_rd_data", 32'(mem_o), 32'(ref_mem[16'h0050]));
    @(negedge clk_i); #1;
    check_eq("spend_cpuen", 32'(cpuEn_o), 32'd1);
    core_done_i = 1'b1;
    @(negedge clk_i); core_done_i = 1'b0; #1;
    ref_steps = ref_steps + 16'd1;
    check_eq("spend_count", 32'(step_count_o), 32'(ref_steps));

    // Reset in the middle of a read.
    mem_wait = 6;
    @(negedge clk_i); memEn_i = 1'b1; memAddr_i = 16'h0060;
    @(negedge clk_i);
    @(negedge clk_i);
    arst_i = 1'b1;
    #1;
    check_eq("arst_cpuen", 32'(cpuEn_o), 32'd0);
    check_eq("arst_halt", 32'(core_halt_o), 32'd1);
    check_eq("arst_mem_o", 32'(mem_o), 32'd0);
    check_eq("arst_bus", 32'(mem_en_o), 32'd0);
    check_eq("arst_steps", 32'(step_count_o), 32'd0);
    memEn_i = 1'b0;
    ref_steps = '0;
    @(negedge clk_i); arst_i = 1'b0;
    @(negedge clk_i); #1;
    check_eq("arst_no_resume", 32'(mem_en_o), 32'd0);

    // Counter wrap.
    @(negedge clk_i);
    force dut.step_count_q = 16'hFFFF;
    @(negedge clk_i);
    release dut.step_count_q;
    ref_steps = 16'hFFFF;
    do_step(2);

    for (int i = 0; i < 30; i++) begin
      addr = {12'h0A0, 4'($urandom_range(0, 15))};
      case ($urandom_range(0, 3))
        0:       do_read(addr, $urandom_range(0, 3), 1'b0);
        1:       do_write(addr, 16'($urandom), $urandom_range(0, 3));
        2:       do_step($urandom_range(0, 6));
        default: do_reg(3'($urandom), 16'($urandom));
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
